// File: rtl/card_table_scheduler_pkg.sv
// Shared types and constants for the card table video-slot scheduler.
// Tile addresses are {row, col} in the low 8 bits; the bypass register sits at 14'h2000.
package card_table_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [13:0] BYPASS_ADDR = 14'h2000;
    localparam int          ROW_W       = 3;
    localparam int          COL_W       = 5;
    localparam int          IDX_W       = ROW_W + COL_W;

    function automatic logic [13:0] tile_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        return {6'b0, row, col};
    endfunction

endpackage

// File: rtl/card_deal_fifo.sv
// Synchronous first-word-fall-through queue for pending deal requests.
// DEPTH must be a power of two (at least 2); the extra pointer bit separates full from empty.
module card_deal_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/card_table_scheduler.sv
// Arbitrates the single video-core slot between CPU, bypass register writes,
// whole-table clears and queued card deals; every slot decision is registered onto v_*.
module card_table_scheduler
    import card_table_scheduler_pkg::*;
#(
    parameter int unsigned          CODE_W     = 6,
    parameter logic [CODE_W-1:0]    BLANK_CODE = '0,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              deal_valid,
    output logic              deal_ready,
    input  logic [2:0]        deal_row,
    input  logic [4:0]        deal_col,
    input  logic [CODE_W-1:0] deal_code,
    input  logic              clear_req,
    input  logic              bypass_set,
    input  logic              bypass_val,
    input  logic              cpu_cs,
    input  logic              cpu_write,
    input  logic [13:0]       cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic              v_cs,
    output logic              v_write,
    output logic [13:0]       v_addr,
    output logic [31:0]       v_wr_data,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEAL_W = ROW_W + COL_W + int'(CODE_W);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               done_next;

    logic               bypass_pending;
    logic               bypass_latched;
    logic               grant_bypass;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DEAL_W-1:0]  fifo_wr_data;
    logic [DEAL_W-1:0]  fifo_rd_data;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [CODE_W-1:0]  rd_code;

    logic               slot_cs;
    logic               slot_write;
    logic [13:0]        slot_addr;
    logic [31:0]        slot_data;

    assign deal_ready   = !fifo_full;
    assign fifo_push    = deal_valid && !fifo_full;
    assign fifo_wr_data = {deal_row, deal_col, deal_code};
    assign rd_row       = fifo_rd_data[DEAL_W-1 -: ROW_W];
    assign rd_col       = fifo_rd_data[int'(CODE_W) +: COL_W];
    assign rd_code      = fifo_rd_data[CODE_W-1:0];

    card_deal_fifo #(
        .WIDTH (DEAL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_deal_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Deals only leave the queue in IDLE, so anything queued during a clear lands after it.
    always_comb begin
        slot_cs      = 1'b0;
        slot_write   = 1'b0;
        slot_addr    = '0;
        slot_data    = '0;
        grant_bypass = 1'b0;
        fifo_pop     = 1'b0;
        state_next   = state;
        idx_next     = idx;
        done_next    = 1'b0;

        if (cpu_cs) begin
            slot_cs    = 1'b1;
            slot_write = cpu_write;
            slot_addr  = cpu_addr;
            slot_data  = cpu_wr_data;
        end else if (bypass_pending) begin
            grant_bypass = 1'b1;
            slot_cs      = 1'b1;
            slot_write   = 1'b1;
            slot_addr    = BYPASS_ADDR;
            slot_data    = {31'b0, bypass_latched};
        end else if (state == CLEAR) begin
            slot_cs    = 1'b1;
            slot_write = 1'b1;
            slot_addr  = tile_addr(idx[IDX_W-1 -: ROW_W], idx[COL_W-1:0]);
            slot_data  = 32'(BLANK_CODE);
            idx_next   = idx + 1'b1;
            if (idx == {IDX_W{1'b1}}) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            slot_cs    = 1'b1;
            slot_write = 1'b1;
            slot_addr  = tile_addr(rd_row, rd_col);
            slot_data  = 32'(rd_code);
        end

        if (clear_req) begin
            state_next = CLEAR;
            idx_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            clear_done <= done_next;
        end
    end

    // A new bypass_set wins over an issue in the same cycle, so the latest value is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bypass_pending <= 1'b0;
            bypass_latched <= 1'b0;
        end else if (bypass_set) begin
            bypass_pending <= 1'b1;
            bypass_latched <= bypass_val;
        end else if (grant_bypass) begin
            bypass_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_cs      <= 1'b0;
            v_write   <= 1'b0;
            v_addr    <= '0;
            v_wr_data <= '0;
        end else begin
            v_cs      <= slot_cs;
            v_write   <= slot_write;
            v_addr    <= slot_addr;
            v_wr_data <= slot_data;
        end
    end

    assign busy = (state == CLEAR) || !fifo_empty || bypass_pending;

endmodule

// File: doc/card_table_scheduler.md
CARD_TABLE_SCHEDULER -- requirements
Module: card_table_scheduler

Interface
REQ-001 Parameters SHALL be: CODE_W, default 6, card tile code width; BLANK_CODE, default 0, code written by a clear (matches the video core key colour tile); FIFO_DEPTH, default 4, deal queue depth (power of two).
REQ-002 The block SHALL use reset as an asynchronous, active-high reset and clk as its clock.
REQ-003 Ports SHALL be:
- clk, input, 1, clock
- reset, input, 1, async active-high reset
- deal_valid, input, 1, deal request valid
- deal_ready, output, 1, deal queue can accept
- deal_row, input, 3, tile row (yt)
- deal_col, input, 5, tile column (xt)
- deal_code, input, CODE_W, card tile code
- clear_req, input, 1, one-cycle pulse: blank whole table
- bypass_set, input, 1, one-cycle pulse: update bypass
- bypass_val, input, 1, bypass value
- cpu_cs, input, 1, CPU slot select
- cpu_write, input, 1, CPU write strobe
- cpu_addr, input, 14, CPU slot address
- cpu_wr_data, input, 32, CPU write data
- v_cs, output, 1, video slot select
- v_write, output, 1, video slot write
- v_addr, output, 14, video slot address
- v_wr_data, output, 32, video slot data
- busy, output, 1, clear running or queue non-empty
- clear_done, output, 1, one-cycle pulse after final clear write

Function
REQ-004 All v_* outputs SHALL be registered: a slot decision made in cycle N SHALL appear on v_* in cycle N+1.
REQ-005 Per-cycle slot priority SHALL be: CPU (cpu_cs=1) > pending bypass write > clear step > deal pop; exactly one source or none SHALL own the slot each cycle.
REQ-006 A CPU cycle SHALL forward cpu_cs, cpu_write, cpu_addr, cpu_wr_data unchanged; CPU is never stalled.
REQ-007 A tile write SHALL drive v_cs=1, v_write=1, v_addr={6'b0, row[2:0], col[4:0]}, v_wr_data=zero-extended code.
REQ-008 A bypass write SHALL drive v_cs=1, v_write=1, v_addr=14'h2000, v_wr_data={31'b0, bypass_val_latched}.
REQ-009 bypass_set SHALL latch bypass_val and set a pending flag; a later bypass_set before issue SHALL overwrite the value (latest wins); the flag SHALL clear when the write issues.
REQ-010 Idle slot SHALL drive v_cs=0, v_write=0, v_addr=0, v_wr_data=0.
REQ-011 FSM states SHALL be IDLE and CLEAR; clear_req in any state SHALL enter CLEAR with the 8-bit tile index reset to 0.
REQ-012 In CLEAR, each granted clear step SHALL write BLANK_CODE at index {row,col}=idx and increment idx; steps blocked by higher priority SHALL not advance idx.
REQ-013 After writing idx=255 the FSM SHALL return to IDLE and assert clear_done for exactly the following cycle.
REQ-014 Deal requests SHALL be buffered in a FIFO_DEPTH FIFO; push when deal_valid && deal_ready; deal_ready = not full.
REQ-015 Deals SHALL be popped only in IDLE, in arrival order, one per granted cycle; deals queued during CLEAR SHALL be held and issued after the clear, so they are not blanked.
REQ-016 Simultaneous push and pop SHALL both take effect with occupancy unchanged.
REQ-017 busy SHALL equal (state==CLEAR) or (FIFO not empty) or bypass pending.

Reset
REQ-018 On reset: state IDLE, idx 0, FIFO empty, bypass pending 0, latched bypass value 0, all v_* 0, clear_done 0, busy 0, deal_ready 1.
REQ-019 Reset mid-clear or with queued deals SHALL abandon them with no further slot writes.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the bypass register address 14'h2000, and tile row/column widths (3, 5).
REQ-021 The deal queue SHALL be one sub-module, card_deal_fifo (synchronous, first-word-fall-through, full/empty flags).

Verification
REQ-022 Reset, then one deal row 2 col 5 code 6'h11 -> next cycle v_addr=14'h045, v_wr_data=32'h11, v_write=1; busy low afterwards.
REQ-023 clear_req with no interference -> exactly 256 writes of BLANK_CODE to addresses 0..255 in order, clear_done pulses once, one cycle after the addr-255 write.
REQ-024 Five deals back-to-back while a clear runs -> deal_ready low after four; the four queued deals issue in order after clear_done, the fifth is accepted once deal_ready rises.
REQ-025 CPU write cpu_addr=14'h0010 during clear step idx=16 -> CPU forwarded that cycle; idx=16 written the following free cycle; no index skipped.
REQ-026 bypass_set val=1 then val=0 while CPU holds slot for 3 cycles -> one write to 14'h2000 with data 0 after CPU releases.
REQ-027 Reset asserted at idx=100 with two deals queued -> all v_* 0, busy 0 and no further writes after reset releases.
